// File: rtl/cpu_sequencer.sv
// Fetch/execute timing sequencer. It runs FETCH0..FETCH2, then a variable-length EXEC phase, with HALT and a sticky FAULT state.
// Optional macro SINGLE_STEP_EN adds Step_Mode/Step_Go for single-instruction stepping.
module cpu_sequencer #(
    parameter int STEP_W   = 3,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Stop,
    input  logic              Con_FF,
    input  logic              Mem_Ack,
    input  logic [STEP_W-1:0] Exec_Len,
    input  logic              Exec_Wait,
    input  logic              Con_Sample,
`ifdef SINGLE_STEP_EN
    input  logic              Step_Mode,
    input  logic              Step_Go,
`endif
    output logic              Run,
    output logic              Halted,
    output logic              Fault,
    output logic              Ph_Fetch0,
    output logic              Read_Req,
    output logic              Ph_Fetch2,
    output logic              Exec_Valid,
    output logic [STEP_W-1:0] Step,
    output logic              Cond,
    output logic [CNT_W-1:0]  Instr_Count
);

    typedef enum logic [2:0] {
        S_FETCH0,
        S_FETCH1,
        S_FETCH2,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    localparam int                WAIT_W    = 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [STEP_W-1:0] step_q, step_nxt;
    logic [STEP_W-1:0] len_q, len_nxt, len_eff;
    logic              len_fresh, len_fresh_nxt;
    logic              cond_q, cond_nxt;
    logic [CNT_W-1:0]  count_q, count_nxt;
    logic              last_step;
    logic              halt_exit;
    logic              retire_to_halt;

    // NOTE: every register here, including the latched length, has a defined reset value.
    // The sequencer must restart cleanly from any state, FAULT included.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= S_FETCH0;
            wait_cnt  <= '0;
            step_q    <= '0;
            len_q     <= STEP_W'(1);
            len_fresh <= 1'b0;
            cond_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            // NOTE: non-blocking so all registers update from the same pre-edge values.
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            step_q    <= step_nxt;
            len_q     <= len_nxt;
            len_fresh <= len_fresh_nxt;
            cond_q    <= cond_nxt;
            count_q   <= count_nxt;
        end
    end

    // The first EXEC cycle decides on the live Exec_Len. Later cycles use the latched copy.
    always_comb begin
        len_eff   = len_fresh ? ((Exec_Len == '0) ? STEP_W'(1) : Exec_Len) : len_q;
        last_step = (step_q == len_eff - STEP_W'(1));
`ifdef SINGLE_STEP_EN
        halt_exit      = !Stop && Step_Go;
        retire_to_halt = Stop || Step_Mode;
`else
        halt_exit      = !Stop;
        retire_to_halt = Stop;
`endif
    end

    always_comb begin
        // NOTE: defaults first, so a branch that assigns nothing keeps the value and no latch forms.
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        step_nxt      = step_q;
        len_nxt       = len_q;
        len_fresh_nxt = len_fresh;
        cond_nxt      = cond_q;
        count_nxt     = count_q;

        case (state)
            S_FETCH0: begin
                if (Stop) begin
                    state_nxt = S_HALT;
                end else begin
                    state_nxt    = S_FETCH1;
                    wait_cnt_nxt = '0;
                end
            end
            S_FETCH1: begin
                // An acknowledge on the final allowed cycle still counts as a successful fetch.
                if (Mem_Ack) begin
                    state_nxt = S_FETCH2;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_FAULT;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            S_FETCH2: begin
                state_nxt     = S_EXEC;
                step_nxt      = '0;
                len_fresh_nxt = 1'b1;
            end
            S_EXEC: begin
                if (Con_Sample) begin
                    cond_nxt = Con_FF;
                end
                if (len_fresh) begin
                    len_nxt       = len_eff;
                    len_fresh_nxt = 1'b0;
                end
                if (!Exec_Wait) begin
                    if (last_step) begin
                        step_nxt  = '0;
                        count_nxt = count_q + CNT_W'(1);
                        state_nxt = retire_to_halt ? S_HALT : S_FETCH0;
                    end else begin
                        step_nxt = step_q + STEP_W'(1);
                    end
                end
            end
            S_HALT: begin
                if (halt_exit) begin
                    state_nxt = S_FETCH0;
                end
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: begin
                state_nxt = S_FAULT;
            end
        endcase
    end

    assign Run         = (state == S_FETCH0) || (state == S_FETCH1) ||
                         (state == S_FETCH2) || (state == S_EXEC);
    assign Halted      = (state == S_HALT);
    assign Fault       = (state == S_FAULT);
    assign Ph_Fetch0   = (state == S_FETCH0);
    assign Read_Req    = (state == S_FETCH1);
    assign Ph_Fetch2   = (state == S_FETCH2);
    assign Exec_Valid  = (state == S_EXEC);
    assign Step        = step_q;
    assign Cond        = cond_q;
    assign Instr_Count = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: an instruction-level plan gives the per-cycle drive, the expected phases and the retire/halt events.
// A separate monitor compares the DUT against them. Directed fault, reset and single-step sections follow.
module tb_cpu_sequencer;

    localparam int STEP_W   = 3;
    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 4;

    localparam logic [2:0] PH_F0   = 3'd0;
    localparam logic [2:0] PH_F1   = 3'd1;
    localparam logic [2:0] PH_F2   = 3'd2;
    localparam logic [2:0] PH_EX   = 3'd3;
    localparam logic [2:0] PH_HALT = 3'd4;

    typedef struct packed {
        logic              stop;
        logic              con_ff;
        logic              mem_ack;
        logic              exec_wait;
        logic              con_sample;
        logic              go;
        logic [STEP_W-1:0] exec_len;
        logic [2:0]        ph;
        logic [STEP_W-1:0] step;
    } cyc_t;

    typedef struct {
        bit               is_halt;
        int               stamp;
        logic [CNT_W-1:0] count;
        logic             cond;
    } ev_t;

    logic              clk;
    logic              rst_n;
    logic              stop, con_ff, mem_ack, exec_wait, con_sample;
    logic [STEP_W-1:0] exec_len;
    logic              run, halted, fault, ph_fetch0, read_req, ph_fetch2, exec_valid;
    logic [STEP_W-1:0] step;
    logic              cond;
    logic [CNT_W-1:0]  instr_count;
`ifdef SINGLE_STEP_EN
    logic              step_mode, step_go;
`endif

    int               checks = 0;
    int               errors = 0;
    cyc_t             plan[$];
    ev_t              ev_q[$];
    logic [CNT_W-1:0] m_count = '0;
    logic             m_cond  = 1'b0;
    bit               running = 1'b0;
    int               edges   = 0;
    logic [CNT_W-1:0] last_cnt = '0;
    logic             last_halted = 1'b0;

    cpu_sequencer #(.STEP_W(STEP_W), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .Clock      (clk),
        .Reset      (rst_n),
        .Stop       (stop),
        .Con_FF     (con_ff),
        .Mem_Ack    (mem_ack),
        .Exec_Len   (exec_len),
        .Exec_Wait  (exec_wait),
        .Con_Sample (con_sample),
`ifdef SINGLE_STEP_EN
        .Step_Mode  (step_mode),
        .Step_Go    (step_go),
`endif
        .Run        (run),
        .Halted     (halted),
        .Fault      (fault),
        .Ph_Fetch0  (ph_fetch0),
        .Read_Req   (read_req),
        .Ph_Fetch2  (ph_fetch2),
        .Exec_Valid (exec_valid),
        .Step       (step),
        .Cond       (cond),
        .Instr_Count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] obs_vec();
        return {run, halted, fault, ph_fetch0, read_req, ph_fetch2, exec_valid};
    endfunction

    // Output pattern expected in each phase: {Run, Halted, Fault, Ph_Fetch0, Read_Req, Ph_Fetch2, Exec_Valid}
    function automatic logic [6:0] exp_vec(input logic [2:0] ph);
        case (ph)
            PH_F0:   return 7'b1001000;
            PH_F1:   return 7'b1000100;
            PH_F2:   return 7'b1000010;
            PH_EX:   return 7'b1000001;
            PH_HALT: return 7'b0100000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic cyc_t rnd_idle(input bit rnd);
        cyc_t c;
        c = '0;
        if (rnd) begin
            c.stop       = ($urandom_range(0, 3) == 0);
            c.con_ff     = 1'($urandom_range(0, 1));
            c.mem_ack    = 1'($urandom_range(0, 1));
            c.exec_wait  = 1'($urandom_range(0, 1));
            c.con_sample = ($urandom_range(0, 2) == 0);
            c.go         = 1'($urandom_range(0, 1));
            c.exec_len   = STEP_W'($urandom_range(0, 7));
        end
        return c;
    endfunction

    task automatic apply(input cyc_t c);
        stop       = c.stop;
        con_ff     = c.con_ff;
        mem_ack    = c.mem_ack;
        exec_wait  = c.exec_wait;
        con_sample = c.con_sample;
        exec_len   = c.exec_len;
`ifdef SINGLE_STEP_EN
        step_mode  = 1'b0;
        step_go    = c.go;
`endif
    endtask

    // h HALT cycles hold Stop high. The exit cycle drops Stop and pulses Step_Go.
    task automatic gen_halt(input int h);
        cyc_t c;
        for (int i = 0; i < h; i++) begin
            c = rnd_idle(1'b1);
            c.stop = 1'b1;
            c.ph   = PH_HALT;
            plan.push_back(c);
        end
        c = rnd_idle(1'b1);
        c.stop = 1'b0;
        c.go   = 1'b1;
        c.ph   = PH_HALT;
        plan.push_back(c);
    endtask

    task automatic gen_f0_halt(input int h);
        cyc_t c;
        c = rnd_idle(1'b1);
        c.stop = 1'b1;
        c.ph   = PH_F0;
        ev_q.push_back('{is_halt: 1'b1, stamp: plan.size() + 1, count: m_count, cond: m_cond});
        plan.push_back(c);
        gen_halt(h);
    endtask

    // One instruction. d = FETCH1 cycles before the acknowledge, w0 = forced waits on step 0 (-1 means random).
    task automatic gen_instr(input int d, input int len, input int stop_step, input int halt_extra,
                             input bit rnd, input int w0, input bit samp);
        cyc_t c;
        int   eff;
        int   w;
        bit   stopping;
        bit   first;
        bit   final_c;
        c = rnd_idle(rnd);
        c.stop = 1'b0;
        c.ph   = PH_F0;
        plan.push_back(c);
        for (int i = 0; i <= d; i++) begin
            c = rnd_idle(rnd);
            c.mem_ack = (i == d);
            c.ph      = PH_F1;
            plan.push_back(c);
        end
        c = rnd_idle(rnd);
        c.ph = PH_F2;
        plan.push_back(c);
        eff      = (len == 0) ? 1 : len;
        stopping = 1'b0;
        first    = 1'b1;
        for (int s = 0; s < eff; s++) begin
            if (s == 0 && w0 >= 0)
                w = w0;
            else if (rnd && $urandom_range(0, 3) == 0)
                w = $urandom_range(1, 3);
            else
                w = 0;
            if (s == stop_step) stopping = 1'b1;
            for (int j = 0; j <= w; j++) begin
                final_c = (s == eff - 1) && (j == w);
                c = rnd_idle(rnd);
                c.exec_wait = (j < w);
                c.stop      = stopping || (!final_c && c.stop);
                c.ph        = PH_EX;
                c.step      = STEP_W'(s);
                if (first || !rnd) c.exec_len = STEP_W'(len);
                if (first && samp) begin
                    c.con_sample = 1'b1;
                    c.con_ff     = 1'b1;
                end
                first = 1'b0;
                if (c.con_sample) m_cond = c.con_ff;
                if (final_c) begin
                    m_count = m_count + 1'b1;
                    ev_q.push_back('{is_halt: 1'b0, stamp: plan.size() + 1, count: m_count, cond: m_cond});
                    if (stopping)
                        ev_q.push_back('{is_halt: 1'b1, stamp: plan.size() + 1, count: m_count, cond: m_cond});
                end
                plan.push_back(c);
            end
        end
        if (stopping) gen_halt(halt_extra);
    endtask

    // Monitor: per-cycle phase/step against the plan, and retire/halt events against the scoreboard queue.
    initial begin
        ev_t  e;
        cyc_t p;
        forever begin
            @(posedge clk);
            if (running) edges++;
            else edges = 0;
            @(negedge clk);
            if (running) begin
                if (edges < plan.size()) begin
                    p = plan[edges];
                    check("phase", obs_vec(), exp_vec(p.ph));
                    if (p.ph == PH_EX) check("step", step, p.step);
                end
                if (instr_count !== last_cnt) begin
                    if (ev_q.size() != 0 && !ev_q[0].is_halt) begin
                        e = ev_q.pop_front();
                        check("retire_time", edges, e.stamp);
                        check("retire_count", instr_count, e.count);
                        check("retire_cond", cond, e.cond);
                    end else begin
                        check("retire_unexpected", instr_count, last_cnt);
                    end
                end
                if (halted && !last_halted) begin
                    if (ev_q.size() != 0 && ev_q[0].is_halt) begin
                        e = ev_q.pop_front();
                        check("halt_time", edges, e.stamp);
                    end else begin
                        check("halt_unexpected", halted, last_halted);
                    end
                end
            end
            last_cnt    = instr_count;
            last_halted = halted;
        end
    end

    initial begin
        int k;
        int rr;
        int fault_at;
        int d, len, ss;
        rst_n = 1'b0;
        apply('0);

        // Directed prefix, then random instructions.
        for (int n = 0; n < 3; n++) gen_instr(0, 3, -1, 0, 1'b0, 0, 1'b0);
        gen_instr(4, 3, -1, 0, 1'b0, 0, 1'b0);
        gen_instr(0, 4, 0, 2, 1'b0, 0, 1'b0);
        gen_instr(0, 0, -1, 0, 1'b0, 3, 1'b1);
        gen_instr(0, 2, -1, 0, 1'b0, 0, 1'b0);
        gen_instr(WAIT_MAX - 1, 1, -1, 0, 1'b0, 0, 1'b0);
        gen_f0_halt(1);
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) gen_f0_halt($urandom_range(0, 3));
            d   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, WAIT_MAX - 1) : $urandom_range(0, 2);
            len = $urandom_range(0, 7);
            ss  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (len == 0) ? 0 : len - 1) : -1;
            gen_instr(d, len, ss, $urandom_range(0, 3), 1'b1, -1, 1'b0);
        end

        repeat (2) @(negedge clk);
        check("reset_outputs", obs_vec(), 7'b1001000);
        check("reset_step", step, 0);
        check("reset_cond", cond, 0);
        check("reset_count", instr_count, 0);

        rst_n = 1'b1;
        apply(plan[0]);
        running = 1'b1;
        for (int i = 1; i < plan.size(); i++) begin
            @(negedge clk);
            apply(plan[i]);
            if (errors > 40) break;
        end
        @(negedge clk);
        #1;
        running = 1'b0;
        check("events_left", ev_q.size(), 0);
        check("final_count", instr_count, m_count);
        check("final_cond", cond, m_cond);

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", obs_vec(), 7'b1001000);
        check("async_reset_count", instr_count, 0);
        check("async_reset_cond", cond, 0);

        // Fetch timeout: Mem_Ack never arrives.
        apply('0);
        @(negedge clk);
        rst_n = 1'b1;
        rr = 0;
        fault_at = -1;
        for (k = 1; k <= 40 && fault_at < 0; k++) begin
            @(negedge clk);
            if (read_req) rr++;
            if (fault) fault_at = k;
        end
        check("fault_cycle", fault_at, WAIT_MAX + 1);
        check("fault_read_req_cycles", rr, WAIT_MAX);
        for (int i = 0; i < 6; i++) begin
            stop    = i[0];
            mem_ack = 1'b1;
            @(negedge clk);
            check("fault_sticky", obs_vec(), 7'b0010000);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_from_fault", obs_vec(), 7'b1001000);

`ifdef SINGLE_STEP_EN
        // Single-step mode: one instruction per Step_Go pulse, with pulses outside HALT ignored.
        apply('0);
        step_mode = 1'b1;
        mem_ack   = 1'b1;
        exec_len  = 3'd2;
        @(negedge clk);
        rst_n = 1'b1;
        fault_at = -1;
        for (k = 1; k <= 20 && fault_at < 0; k++) begin
            @(negedge clk);
            step_go = (k == 3);
            if (halted) fault_at = k;
        end
        step_go = 1'b0;
        check("ss_first_halt_cycle", fault_at, 5);
        check("ss_first_count", instr_count, 1);
        repeat (3) @(negedge clk);
        check("ss_hold_halt", obs_vec(), 7'b0100000);
        step_go = 1'b1;
        @(negedge clk);
        step_go = 1'b0;
        check("ss_go_fetch0", obs_vec(), 7'b1001000);
        fault_at = -1;
        for (k = 1; k <= 20 && fault_at < 0; k++) begin
            @(negedge clk);
            if (halted) fault_at = k;
        end
        check("ss_second_halt_cycle", fault_at, 5);
        check("ss_second_count", instr_count, 2);
        repeat (4) @(negedge clk);
        check("ss_stay_halted", obs_vec(), 7'b0100000);
        check("ss_stay_count", instr_count, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Parametrised fetch/execute timing sequencer; the next generation of the control-unit timing core in the CPU top.
- Drives fetch phases and execute step count (T-states) consumed by the control-signal decoder.
- New over the fixed-timing core:
  - variable-length execute phase;
  - memory-acknowledge wait states with timeout fault;
  - clean Stop/halt at instruction boundary;
  - latched condition flag;
  - retired-instruction counter.

Parameters:
- STEP_W, 3, width of execute step counter and Exec_Len; max 2^STEP_W-1 execute steps.
- WAIT_MAX, 15, max cycles waiting for Mem_Ack in FETCH1 before fault; 1..255.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- Clock  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Stop  in  1  level halt request.
- Con_FF  in  1  branch condition from datapath CON flip-flop.
- Mem_Ack  in  1  memory read data valid.
- Exec_Len  in  STEP_W  execute step count from decoder.
- Exec_Wait  in  1  hold current execute step (memory access in progress).
- Con_Sample  in  1  capture Con_FF this execute step.
- Run  out  1  high in FETCH0/FETCH1/FETCH2/EXEC.
- Halted  out  1  high in HALT.
- Fault  out  1  high in FAULT.
- Ph_Fetch0  out  1  PCout/MARIn/IncPC phase.
- Read_Req  out  1  memory read strobe (FETCH1).
- Ph_Fetch2  out  1  MDRout/IRIn phase.
- Exec_Valid  out  1  high in EXEC.
- Step  out  STEP_W  current execute step, 0-based.
- Cond  out  1  latched condition.
- Instr_Count  out  CNT_W  retired instructions, wraps.

Behaviour:
- Reset low, asynchronous:
  - state = FETCH0.
  - Step=0, Cond=0, Instr_Count=0, wait counter=0, latched length=1.
  - Reset mid-operation (any state, including FAULT) aborts immediately.
- Outputs: Moore-decoded from state, registered state only.
  - Reset held: Ph_Fetch0=1, Run=1; all other single-bit outputs 0.
- FETCH0 (1 cycle):
  - Stop=1 -> HALT; no memory access issued.
  - Else -> FETCH1, wait counter cleared.
- FETCH1 (Read_Req=1):
  - Mem_Ack=1 -> FETCH2.
  - Else wait counter +1; Mem_Ack not seen after WAIT_MAX waiting cycles -> FAULT.
  - Mem_Ack on the last allowed cycle wins over fault.
- FETCH2 (1 cycle) -> EXEC, Step=0.
- EXEC:
  - On Step 0 first cycle, latch Exec_Len; 0 latched as 1.
  - Exec_Wait=1 freezes Step and state; no timeout applies.
  - Con_Sample=1 (with Exec_Valid) -> Cond <= Con_FF at that edge; Cond holds otherwise, including across instructions.
  - Step advances by 1 per non-waiting cycle.
  - On last step (Step == latched length-1, Exec_Wait=0):
    - Instr_Count +1, wrapping 2^CNT_W-1 -> 0.
    - Next state: HALT if Stop=1, else FETCH0.
  - Stop during non-final steps has no effect until the last step.
- HALT: Halted=1, Run=0. Stop=0 -> FETCH0 next edge.
- FAULT: Fault=1, Run=0. Sticky until Reset.
- Latency:
  - fetch = 3 cycles with Mem_Ack in first FETCH1 cycle.
  - instruction = 3 + Exec_Len cycles, plus wait cycles.

Optional Feature:
- Macro SINGLE_STEP_EN.
- Defined:
  - Adds inputs Step_Mode (1) and Step_Go (1).
  - With Step_Mode=1, instruction completion always enters HALT.
  - In HALT, exit to FETCH0 requires Stop=0 and Step_Go=1 (single-cycle pulse); exactly one instruction then executes.
  - Step_Go outside HALT is ignored.
- Undefined: ports absent; HALT exit on Stop=0 only.

Test Plan:
- Reset release, Mem_Ack tied 1, Exec_Len=3, Stop=0:
  - states FETCH0,FETCH1,FETCH2,EXEC steps 0,1,2 repeat every 6 cycles.
  - Instr_Count = 1,2,3 after cycles 6,12,18.
- Mem_Ack delayed 4 cycles, WAIT_MAX=15:
  - Read_Req high 5 cycles, then FETCH2; no fault.
- Mem_Ack never asserted:
  - FAULT after WAIT_MAX cycles of Read_Req; Fault stays 1 through Stop toggles.
  - Reset low clears to FETCH0.
- Stop raised at EXEC Step 0, Exec_Len=4:
  - steps 1..3 still execute, Instr_Count +1, then HALT.
  - Stop=0 -> FETCH0 next edge.
- Exec_Len=0, Exec_Wait=1 for 3 cycles on Step 0, Con_Sample=1 with Con_FF=1:
  - single EXEC step lasting 4 cycles, then Cond=1.
  - Cond still 1 through next instruction with Con_Sample=0.
- SINGLE_STEP_EN, Step_Mode=1:
  - each Step_Go pulse yields exactly one Instr_Count increment, then HALT.
  - Step_Go during EXEC ignored.
